// File: rtl/systolic_array_controller_if.sv
// Job / feed bundle between the systolic array controller and its surroundings.
// The controller uses the slave modport; the job source uses master.
interface systolic_array_controller_if #(
  parameter int N   = 4,
  parameter int K_W = 8
);
  logic           start;
  logic [K_W-1:0] k_len;
  logic           ready;
  logic           busy;
  logic           pe_clear;
  logic           feed_valid;
  logic [K_W-1:0] feed_idx;
  logic [N-1:0]   row_en;
  logic [N-1:0]   col_en;
  logic           drain;
  logic           done;

  modport master (
    output start, k_len,
    input  ready, busy, pe_clear, feed_valid, feed_idx, row_en, col_en, drain, done
  );

  modport slave (
    input  start, k_len,
    output ready, busy, pe_clear, feed_valid, feed_idx, row_en, col_en, drain, done
  );
endinterface

// File: rtl/systolic_array_controller.sv
// Sequencer for an NxN systolic MAC array: clear, skewed K-step feed, drain, done.
// Optional abort input enabled by defining SA_ABORT_EN.
module systolic_array_controller #(
  parameter int N       = 4,
  parameter int K_W     = 8,
  parameter int ACC_LAT = 2
) (
  input  logic                      clk,
  input  logic                      clear,
  systolic_array_controller_if.slave bus
`ifdef SA_ABORT_EN
  ,
  input  logic                      abort
`endif
);

  localparam int D  = 2 * N - 2 + ACC_LAT;
  localparam int DW = (D > 2) ? $clog2(D) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(D - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [K_W-1:0] kreg_r;
  logic [K_W-1:0] idx_r;
  logic [DW-1:0]  dcnt_r;
  logic [N-2:0]   skew_r;
  logic           abort_hit_s;
  logic           feed_last_s;
  logic           pe_clear_extra_s;

`ifdef SA_ABORT_EN
  logic abort_clr_r;
  assign abort_hit_s      = abort && ((state_r == CLR) || (state_r == FEED) || (state_r == DRAIN));
  assign pe_clear_extra_s = abort_clr_r;
`else
  assign abort_hit_s      = 1'b0;
  assign pe_clear_extra_s = 1'b0;
`endif

  assign feed_last_s = (idx_r == (kreg_r - K_W'(1)));

  // Next-state decode
  always_comb begin
    state_s = state_r;
    if (abort_hit_s) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = bus.start ? CLR : IDLE;
        CLR:     state_s = (kreg_r == {K_W{1'b0}}) ? DONE : FEED;
        FEED:    state_s = feed_last_s ? DRAIN : FEED;
        DRAIN:   state_s = (dcnt_r == {DW{1'b0}}) ? DONE : DRAIN;
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State, job length, feed/drain counters and skew shift register
  always_ff @(posedge clk) begin
    if (!clear) begin
      state_r <= IDLE;
      kreg_r  <= {K_W{1'b0}};
      idx_r   <= {K_W{1'b0}};
      dcnt_r  <= {DW{1'b0}};
      skew_r  <= {(N-1){1'b0}};
`ifdef SA_ABORT_EN
      abort_clr_r <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
`ifdef SA_ABORT_EN
      abort_clr_r <= abort_hit_s;
`endif
      // Skew keeps shifting through DRAIN so the last rows/columns see their tail
      if (abort_hit_s) begin
        skew_r <= {(N-1){1'b0}};
      end else begin
        skew_r[0] <= bus.feed_valid;
        for (int i = 1; i < N - 1; i++) begin
          skew_r[i] <= skew_r[i-1];
        end
      end
      case (state_r)
        IDLE: begin
          idx_r <= {K_W{1'b0}};
          if (bus.start) begin
            kreg_r <= bus.k_len;
          end else begin
            kreg_r <= kreg_r;
          end
        end
        FEED: begin
          if (feed_last_s) begin
            idx_r  <= {K_W{1'b0}};
            dcnt_r <= DRAIN_LOAD;
          end else begin
            idx_r  <= idx_r + K_W'(1);
          end
        end
        DRAIN: begin
          if (dcnt_r != {DW{1'b0}}) begin
            dcnt_r <= dcnt_r - DW'(1);
          end else begin
            dcnt_r <= dcnt_r;
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  assign bus.ready      = (state_r == IDLE);
  assign bus.busy       = (state_r != IDLE);
  assign bus.pe_clear   = (state_r == CLR) || pe_clear_extra_s;
  assign bus.feed_valid = (state_r == FEED);
  assign bus.feed_idx   = (state_r == FEED) ? idx_r : {K_W{1'b0}};
  assign bus.row_en     = {skew_r, bus.feed_valid};
  assign bus.col_en     = {skew_r, bus.feed_valid};
  assign bus.drain      = (state_r == DRAIN);
  assign bus.done       = (state_r == DONE);

endmodule

// File: tb/tb_systolic_array_controller.sv
// Randomised + directed bench for systolic_array_controller against a job-timeline model.
module tb_systolic_array_controller;
  localparam int N       = 4;
  localparam int K_W     = 8;
  localparam int ACC_LAT = 2;
  localparam int D       = 2 * N - 2 + ACC_LAT;
`ifdef SA_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic clear;
`ifdef SA_ABORT_EN
  logic abort;
`endif

  always #5 clk = ~clk;

  systolic_array_controller_if #(.N(N), .K_W(K_W)) bus ();

  systolic_array_controller #(.N(N), .K_W(K_W), .ACC_LAT(ACC_LAT)) dut (
    .clk   (clk),
    .clear (clear),
`ifdef SA_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int done_seen = 0;

  // Model: phase = cycles since the accepting edge (-1 = idle)
  int m_phase = -1;
  int m_k     = 0;
  bit m_fv [N];
  bit m_aclr  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    else passed++;
  endtask

  function automatic int done_phase();
    return (m_k == 0) ? 2 : m_k + 2 + D;
  endfunction

  function automatic bit model_fv();
    return (m_k > 0) && (m_phase >= 2) && (m_phase <= m_k + 1);
  endfunction

  task automatic model_edge(input bit st, input int k, input bit clr_n, input bit ab);
    if (!clr_n) begin
      m_phase = -1;
      m_k     = 0;
      m_aclr  = 1'b0;
      for (int i = 0; i < N; i++) m_fv[i] = 1'b0;
    end else begin
      for (int i = N - 1; i >= 1; i--) m_fv[i] = m_fv[i-1];
      m_aclr = 1'b0;
      if (m_phase < 0) begin
        if (st) begin
          m_phase = 1;
          m_k     = k;
        end
      end else if (ab && ABORT_EN && (m_phase < done_phase())) begin
        m_phase = -1;
        m_aclr  = 1'b1;
        for (int i = 1; i < N; i++) m_fv[i] = 1'b0;
      end else if (m_phase == done_phase()) begin
        m_phase = -1;
      end else begin
        m_phase++;
      end
      m_fv[0] = model_fv();
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] en_e;
    bit fv_e;
    bit dr_e;
    int idx_e;
    for (int i = 0; i < N; i++) en_e[i] = m_fv[i];
    fv_e  = model_fv();
    idx_e = fv_e ? m_phase - 2 : 0;
    dr_e  = (m_k > 0) && (m_phase >= m_k + 2) && (m_phase <= m_k + 1 + D);
    check_eq("ready",      32'(bus.ready),      32'(m_phase < 0));
    check_eq("busy",       32'(bus.busy),       32'(m_phase >= 0));
    check_eq("pe_clear",   32'(bus.pe_clear),   32'((m_phase == 1) || m_aclr));
    check_eq("feed_valid", 32'(bus.feed_valid), 32'(fv_e));
    check_eq("feed_idx",   32'(bus.feed_idx),   32'(idx_e));
    check_eq("row_en",     32'(bus.row_en),     32'(en_e));
    check_eq("col_en",     32'(bus.col_en),     32'(en_e));
    check_eq("drain",      32'(bus.drain),      32'(dr_e));
    check_eq("done",       32'(bus.done),       32'((m_phase >= 0) && (m_phase == done_phase())));
    if (bus.done === 1'b1) done_seen++;
  endtask

  task automatic step(input bit st, input logic [K_W-1:0] k, input bit clr_n, input bit ab);
    bus.start = st;
    bus.k_len = k;
    clear     = clr_n;
`ifdef SA_ABORT_EN
    abort     = ab;
`endif
    @(posedge clk);
    cyc++;
    model_edge(st, int'(k), clr_n, ab);
    #1;
    compare_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, K_W'($urandom), 1'b1, 1'b0);
  endtask

  // Runs one job from idle and checks start-to-done latency
  task automatic run_job(input int k);
    int lat;
    int exp_lat;
    exp_lat = (k == 0) ? 2 : k + 2 * N + ACC_LAT;
    step(1'b1, K_W'(k), 1'b1, 1'b0);
    lat = 1;
    while ((bus.done !== 1'b1) && (lat < 600)) begin
      step(1'b0, K_W'($urandom), 1'b1, 1'b0);
      lat++;
    end
    check_eq("job_latency", 32'(lat), 32'(exp_lat));
    step(1'b0, K_W'(0), 1'b1, 1'b0);
    check_eq("ready_after_done", 32'(bus.ready), 32'd1);
  endtask

  initial begin
    int last_done;
    int n_done;
    int d0;
    int guard;
    bit st;
    bit cl;
    bit ab;
    logic [K_W-1:0] k;

    for (int i = 0; i < N; i++) m_fv[i] = 1'b0;
`ifdef SA_ABORT_EN
    abort = 1'b0;
`endif
    // Reset and idle
    step(1'b0, K_W'(0), 1'b0, 1'b0);
    step(1'b0, K_W'(0), 1'b0, 1'b0);
    check_eq("reset_ready", 32'(bus.ready), 32'd1);
    idle_cycles(2);

    // Directed job lengths including zero and maximum
    run_job(3);
    run_job(0);
    run_job(1);
    run_job(255);
    idle_cycles(2);

    // Back-to-back with start held high
    last_done = -1;
    n_done    = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b1, K_W'(1), 1'b1, 1'b0);
      if (bus.done === 1'b1) begin
        if (last_done >= 0) check_eq("b2b_spacing", 32'(cyc - last_done), 32'(1 + 2 * N + ACC_LAT + 1));
        last_done = cyc;
        n_done++;
      end
    end
    check_eq("b2b_count_ge3", 32'(n_done >= 3), 32'd1);
    idle_cycles(20);

    // Start pulses while busy are ignored
    d0 = done_seen;
    step(1'b1, K_W'(2), 1'b1, 1'b0);
    for (int i = 2; i <= 20; i++) step((i == 3) || (i == 5) || (i == 8), K_W'(7), 1'b1, 1'b0);
    check_eq("busy_start_ignored", 32'(done_seen - d0), 32'd1);

    // Reset mid-feed at feed_idx=1
    d0 = done_seen;
    step(1'b1, K_W'(5), 1'b1, 1'b0);
    guard = 0;
    while (!((bus.feed_valid === 1'b1) && (bus.feed_idx == K_W'(1))) && (guard < 20)) begin
      step(1'b0, K_W'(0), 1'b1, 1'b0);
      guard++;
    end
    check_eq("reach_feed_idx1", 32'(guard < 20), 32'd1);
    step(1'b0, K_W'(0), 1'b0, 1'b0);
    check_eq("midjob_reset_ready", 32'(bus.ready), 32'd1);
    idle_cycles(20);
    check_eq("midjob_reset_no_done", 32'(done_seen - d0), 32'd0);

    // Abort in DRAIN
    if (ABORT_EN) begin
      d0 = done_seen;
      step(1'b1, K_W'(3), 1'b1, 1'b0);
      guard = 0;
      while ((bus.drain !== 1'b1) && (guard < 20)) begin
        step(1'b0, K_W'(0), 1'b1, 1'b0);
        guard++;
      end
      check_eq("reach_drain", 32'(guard < 20), 32'd1);
      step(1'b0, K_W'(0), 1'b1, 1'b1);
      check_eq("abort_idle", 32'(bus.ready), 32'd1);
      check_eq("abort_pe_clear", 32'(bus.pe_clear), 32'd1);
      idle_cycles(15);
      check_eq("abort_no_done", 32'(done_seen - d0), 32'd0);
    end

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 3) == 0);
      k  = ($urandom_range(0, 49) == 0) ? K_W'(255) : K_W'($urandom_range(0, 12));
      cl = ($urandom_range(0, 199) != 0);
      ab = ($urandom_range(0, 39) == 0);
      step(st, k, cl, ab);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
